// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
// pulse_sequencer : NMR pulse programmer (pulse/delay x N, record, gap, x reps)
// Optional abort input: define PULSE_SEQ_ABORT_EN.            Rev 1.0
// ============================================================================
module pulse_sequencer #(
   parameter int N_PULSES = 3,
   parameter int CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
`ifdef PULSE_SEQ_ABORT_EN
   input  logic                      abort,
`endif
   input  logic [N_PULSES*CNT_W-1:0] pulse_len,
   input  logic [N_PULSES*CNT_W-1:0] delay_len,
   input  logic [1:0]                n_pulses,
   input  logic [CNT_W-1:0]          rec_len,
   input  logic [CNT_W-1:0]          rep_gap,
   input  logic [15:0]               n_reps,
   output logic                      enable_gen,
   output logic [1:0]                TX_active_phase,
   output logic                      rec_gate,
   output logic                      busy,
   output logic [15:0]               rep_count,
   output logic                      done
);

   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       NP_MAX = 2'(N_PULSES);

   typedef enum logic [2:0] {IDLE, PULSE, DELAY, RECORD, GAP} state_t;

   typedef struct packed {
      logic             found;
      state_t           st;
      logic [1:0]       idx;
      logic [CNT_W-1:0] cnt;
   } hit_t;

   state_t           state, nxt_state;
   logic [1:0]       idx, nxt_idx;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [15:0]      nxt_rep_count;
   logic [1:0]       nxt_phase;
   logic             nxt_done;
   logic             load;
   logic             advance;
   int               k_from;
   logic [15:0]      rc_base, rc_inc, rc_next;
   hit_t             hit_a, hit_b, hit_sel;

   logic [CNT_W-1:0] sh_pulse [N_PULSES];
   logic [CNT_W-1:0] sh_delay [N_PULSES];
   logic [1:0]       sh_np;
   logic [CNT_W-1:0] sh_rec, sh_gap;
   logic [15:0]      sh_reps;

   logic [CNT_W-1:0] cf_pulse [N_PULSES];
   logic [CNT_W-1:0] cf_delay [N_PULSES];
   logic [1:0]       in_np, cf_np;
   logic [CNT_W-1:0] cf_rec, cf_gap;
   logic [15:0]      in_reps, cf_reps;

   // In IDLE the live inputs are used so the start cycle can already skip zero-length steps.
   assign in_np   = (n_pulses == 2'd0) ? 2'd1 : ((n_pulses > NP_MAX) ? NP_MAX : n_pulses);
   assign in_reps = (n_reps == 16'd0) ? 16'd1 : n_reps;
   assign cf_np   = (state == IDLE) ? in_np   : sh_np;
   assign cf_rec  = (state == IDLE) ? rec_len : sh_rec;
   assign cf_gap  = (state == IDLE) ? rep_gap : sh_gap;
   assign cf_reps = (state == IDLE) ? in_reps : sh_reps;

   for (genvar i = 0; i < N_PULSES; i++) begin : g_cfg
      assign cf_pulse[i] = (state == IDLE) ? pulse_len[i*CNT_W +: CNT_W] : sh_pulse[i];
      assign cf_delay[i] = (state == IDLE) ? delay_len[i*CNT_W +: CNT_W] : sh_delay[i];
   end

   // Steps within a repetition: 2i = PULSE(i), 2i+1 = DELAY(i), 2*np = RECORD.
   // Returns the first non-zero-length step at or after k.
   function automatic hit_t search(input int k);
      hit_t h;
      h = '0;
      for (int i = 0; i < N_PULSES; i++) begin
         if (!h.found && i < int'(cf_np)) begin
            if (2*i >= k && cf_pulse[i] != '0) begin
               h.found = 1'b1;
               h.st    = PULSE;
               h.idx   = 2'(i);
               h.cnt   = cf_pulse[i] - ONE;
            end else if (2*i+1 >= k && cf_delay[i] != '0) begin
               h.found = 1'b1;
               h.st    = DELAY;
               h.idx   = 2'(i);
               h.cnt   = cf_delay[i] - ONE;
            end
         end
      end
      if (!h.found && 2*int'(cf_np) >= k && cf_rec != '0) begin
         h.found = 1'b1;
         h.st    = RECORD;
         h.cnt   = cf_rec - ONE;
      end
      return h;
   endfunction

   always_comb begin
      nxt_state     = state;
      nxt_idx       = idx;
      nxt_cnt       = cnt;
      nxt_rep_count = rep_count;
      nxt_phase     = TX_active_phase;
      nxt_done      = 1'b0;
      load          = 1'b0;
      advance       = 1'b0;
      k_from        = 0;
      rc_base       = rep_count;
      hit_sel       = '0;

      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               advance = 1'b1;
               rc_base = '0;
            end
         end
         PULSE:   k_from = 2*int'(idx) + 1;
         DELAY:   k_from = 2*int'(idx) + 2;
         RECORD:  k_from = 2*int'(cf_np) + 1;
         GAP:     k_from = 0;
         default: k_from = 0;
      endcase

      if (state != IDLE) begin
         if (cnt == '0) advance = 1'b1;
         else           nxt_cnt = cnt - ONE;
      end

      hit_a   = search(k_from);
      hit_b   = search(0);
      rc_inc  = rc_base + 16'd1;
      rc_next = hit_a.found ? rc_base : rc_inc;

      if (advance) begin
         if (!hit_a.found && rc_inc == cf_reps) begin
            nxt_state     = IDLE;
            nxt_done      = 1'b1;
            nxt_rep_count = rc_inc;
         end else if (!hit_a.found && cf_gap != '0) begin
            nxt_state     = GAP;
            nxt_cnt       = cf_gap - ONE;
            nxt_rep_count = rc_inc;
         end else begin
            hit_sel = hit_a.found ? hit_a : hit_b;
            if (hit_sel.found) begin
               nxt_state     = hit_sel.st;
               nxt_cnt       = hit_sel.cnt;
               nxt_rep_count = rc_next;
               if (hit_sel.st != RECORD) nxt_idx   = hit_sel.idx;
               if (hit_sel.st == PULSE)  nxt_phase = hit_sel.idx;
            end else begin
               // Every remaining repetition is zero cycles long.
               nxt_state     = IDLE;
               nxt_done      = 1'b1;
               nxt_rep_count = cf_reps;
            end
         end
      end

`ifdef PULSE_SEQ_ABORT_EN
      if (abort && state != IDLE) begin
         nxt_state     = IDLE;
         nxt_done      = 1'b0;
         nxt_rep_count = rep_count;
         nxt_cnt       = cnt;
         nxt_idx       = idx;
         nxt_phase     = TX_active_phase;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         idx             <= 2'd0;
         cnt             <= '0;
         enable_gen      <= 1'b0;
         TX_active_phase <= 2'd0;
         rec_gate        <= 1'b0;
         busy            <= 1'b0;
         rep_count       <= 16'd0;
         done            <= 1'b0;
         sh_np           <= 2'd0;
         sh_rec          <= '0;
         sh_gap          <= '0;
         sh_reps         <= 16'd0;
         for (int i = 0; i < N_PULSES; i++) begin
            sh_pulse[i] <= '0;
            sh_delay[i] <= '0;
         end
      end else begin
         state           <= nxt_state;
         idx             <= nxt_idx;
         cnt             <= nxt_cnt;
         enable_gen      <= (nxt_state == PULSE);
         TX_active_phase <= nxt_phase;
         rec_gate        <= (nxt_state == RECORD);
         busy            <= (nxt_state != IDLE);
         rep_count       <= nxt_rep_count;
         done            <= nxt_done;
         if (load) begin
            sh_np   <= in_np;
            sh_rec  <= rec_len;
            sh_gap  <= rep_gap;
            sh_reps <= in_reps;
            for (int i = 0; i < N_PULSES; i++) begin
               sh_pulse[i] <= cf_pulse[i];
               sh_delay[i] <= cf_delay[i];
            end
         end
      end
   end

endmodule
`default_nettype wire
